// File: rtl/regfile_wr_if.sv
// Write-request handshake bundle for the register file write port.
interface regfile_wr_if #(
    parameter int WIDTH = 32
);
    logic             wr_valid;
    logic             wr_ready;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/regfile_write_port.sv
// Register file write side: two-stage write pipeline, clear sequencer,
// and flat storage bus for the read-port muxes.
module regfile_write_port #(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    regfile_wr_if.slave        wr,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               commit_valid,
    output logic [4:0]         commit_addr,
    output logic [31:0]        wr_onehot_q,
    output logic [32*WIDTH-1:0] regs_flat
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
    } s1_t;

    localparam logic [4:0] CLR_FIRST = ZERO_REG ? 5'd1 : 5'd0;

    state_t           state;
    state_t           state_nx;
    s1_t              s1;
    logic             accept;
    logic [4:0]       clr_cnt;
    logic [WIDTH-1:0] regs [32];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (clear_req) state_nx = CLEAR;
            CLEAR: if (clr_cnt == 5'd31) state_nx = IDLE;
        endcase
    end

    // clear_req wins over a same-cycle write by withholding ready
    always_comb begin
        clear_busy  = 1'b0;
        wr.wr_ready = 1'b0;
        unique case (1'b1)
            (state == IDLE):  wr.wr_ready = !clear_req;
            (state == CLEAR): clear_busy  = 1'b1;
        endcase
    end

    assign accept = wr.wr_valid && wr.wr_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt <= 5'd0;
        end else if (state == IDLE && clear_req) begin
            clr_cnt <= CLR_FIRST;
        end else if (state == CLEAR && clr_cnt != 5'd31) begin
            clr_cnt <= clr_cnt + 5'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1           <= '0;
            wr_onehot_q  <= '0;
            commit_valid <= 1'b0;
            commit_addr  <= 5'd0;
        end else begin
            s1.valid     <= accept;
            if (accept) begin
                s1.addr <= wr.wr_addr;
                s1.data <= wr.wr_data;
            end
            wr_onehot_q  <= accept ? (32'd1 << wr.wr_addr) : 32'd0;
            commit_valid <= s1.valid;
            if (s1.valid) begin
                commit_addr <= s1.addr;
            end
        end
    end

    // no stage-1 write can be live while CLEAR runs, so the two never collide
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (s1.valid && !(ZERO_REG && s1.addr == 5'd0)) begin
                regs[s1.addr] <= s1.data;
            end
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: directed vectors, corner sequences,
// and randomized traffic against a behavioural model.
module tb_regfile_write_port;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          clear_req;
    logic          clear_busy;
    logic          commit_valid;
    logic [4:0]    commit_addr;
    logic [31:0]   wr_onehot_q;
    logic [1023:0] regs_flat;

    regfile_wr_if #(.WIDTH(32)) wr ();

    regfile_write_port #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr           (wr),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .wr_onehot_q  (wr_onehot_q),
        .regs_flat    (regs_flat)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t        vecs [5];
    logic [31:0] zeros [32];
    logic [31:0] m_regs [32];
    wr_t         pend [$];
    bit          m_busy;
    int          m_idx;
    bit          exp_cv;
    logic [4:0]  exp_ca;
    logic [31:0] exp_oh;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] dreg(input int i);
        return regs_flat[i*32 +: 32];
    endfunction

    task automatic check_regs(input string name, input logic [31:0] e [32]);
        int bad = -1;
        for (int i = 0; i < 32; i++)
            if (bad < 0 && dreg(i) !== e[i]) bad = i;
        n_total++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: reg%0d got %h expected %h",
                      name, bad, dreg(bad), e[bad]);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) begin
            wr.wr_valid = 1'b1;
            wr.wr_addr  = 5'(i);
            wr.wr_data  = 32'(i);
            tick();
        end
        wr.wr_valid = 1'b0;
        tick();
        tick();
    endtask

    // model: accepted writes land one edge later; clear zeroes 1..31 in order
    task automatic model_edge(input bit v, input logic [4:0] a,
                              input logic [31:0] d, input bit creq);
        bit acc;
        acc    = v && !m_busy && !creq;
        exp_cv = 1'b0;
        if (pend.size() > 0) begin
            wr_t w = pend.pop_front();
            if (w.a != 5'd0) m_regs[w.a] = w.d;
            exp_cv = 1'b1;
            exp_ca = w.a;
        end
        if (m_busy) begin
            m_regs[m_idx] = 32'd0;
            if (m_idx == 31) m_busy = 1'b0;
            else m_idx++;
        end else if (creq) begin
            m_busy = 1'b1;
            m_idx  = 1;
        end
        exp_oh = acc ? (32'd1 << a) : 32'd0;
        if (acc) pend.push_back('{a, d});
    endtask

    initial begin
        int  n;
        bit  saw_commit;
        bit  v;
        bit  cr;
        logic [4:0]  a;
        logic [31:0] d;

        for (int i = 0; i < 32; i++) zeros[i] = 32'd0;
        vecs[0] = '{5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{5'd0,  32'hFFFFFFFF, 32'h00000000};
        vecs[2] = '{5'd31, 32'h12345678, 32'h12345678};
        vecs[3] = '{5'd1,  32'h00000001, 32'h00000001};
        vecs[4] = '{5'd16, 32'hA5A5A5A5, 32'hA5A5A5A5};

        reset_n     = 1'b0;
        clear_req   = 1'b0;
        wr.wr_valid = 1'b0;
        wr.wr_addr  = 5'd0;
        wr.wr_data  = 32'd0;
        #2;
        check("rst_onehot", wr_onehot_q, 32'd0);
        check("rst_cv", 32'(commit_valid), 32'd0);
        check("rst_ca", 32'(commit_addr), 32'd0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_ready", 32'(wr.wr_ready), 32'd1);
        check_regs("rst_regs", zeros);
        tick();
        reset_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            wr.wr_valid = 1'b1;
            wr.wr_addr  = vecs[k].addr;
            wr.wr_data  = vecs[k].data;
            #1;
            check("vec_ready", 32'(wr.wr_ready), 32'd1);
            tick();
            wr.wr_valid = 1'b0;
            check("vec_onehot", wr_onehot_q, 32'd1 << vecs[k].addr);
            check("vec_cv_early", 32'(commit_valid), 32'd0);
            tick();
            check("vec_cv", 32'(commit_valid), 32'd1);
            check("vec_ca", 32'(commit_addr), 32'(vecs[k].addr));
            check("vec_reg", dreg(int'(vecs[k].addr)), vecs[k].exp);
            tick();
            check("vec_cv_end", 32'(commit_valid), 32'd0);
            check("vec_onehot_end", wr_onehot_q, 32'd0);
        end

        // back-to-back: 7<=1, 7<=2, 9<=3
        wr.wr_valid = 1'b1; wr.wr_addr = 5'd7; wr.wr_data = 32'h1;
        tick();
        check("b2b_cv0", 32'(commit_valid), 32'd0);
        wr.wr_addr = 5'd7; wr.wr_data = 32'h2;
        tick();
        check("b2b_cv1", 32'(commit_valid), 32'd1);
        check("b2b_ca1", 32'(commit_addr), 32'd7);
        check("b2b_r7a", dreg(7), 32'h1);
        wr.wr_addr = 5'd9; wr.wr_data = 32'h3;
        tick();
        wr.wr_valid = 1'b0;
        check("b2b_cv2", 32'(commit_valid), 32'd1);
        check("b2b_ca2", 32'(commit_addr), 32'd7);
        tick();
        check("b2b_cv3", 32'(commit_valid), 32'd1);
        check("b2b_ca3", 32'(commit_addr), 32'd9);
        tick();
        check("b2b_cv4", 32'(commit_valid), 32'd0);
        check("b2b_r7", dreg(7), 32'h2);
        check("b2b_r9", dreg(9), 32'h3);

        // fill, write addr4 just before clear, then clear with a colliding write
        fill();
        check("fill_r31", dreg(31), 32'd31);
        wr.wr_valid = 1'b1; wr.wr_addr = 5'd4; wr.wr_data = 32'h44;
        tick();
        wr.wr_addr  = 5'd3; wr.wr_data = 32'hAA;
        clear_req   = 1'b1;
        #1;
        check("clr_ready0", 32'(wr.wr_ready), 32'd0);
        tick();
        wr.wr_valid = 1'b0;
        clear_req   = 1'b0;
        check("clr_busy1", 32'(clear_busy), 32'd1);
        check("clr_cv4", 32'(commit_valid), 32'd1);
        check("clr_r4", dreg(4), 32'h44);
        n = 0;
        saw_commit = 1'b0;
        while (clear_busy && n < 100) begin
            clear_req = (n == 5);
            tick();
            if (commit_valid) saw_commit = 1'b1;
            n++;
        end
        clear_req = 1'b0;
        check("clr_cycles", 32'(n), 32'd31);
        check("clr_no_commit", 32'(saw_commit), 32'd0);
        check("clr_ready1", 32'(wr.wr_ready), 32'd1);
        check_regs("clr_regs", zeros);
        tick();
        check("clr_no_restart", 32'(clear_busy), 32'd0);

        // async reset at counter=10
        fill();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (9) tick();
        check("mid_r9", dreg(9), 32'd0);
        check("mid_r20", dreg(20), 32'd20);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(clear_busy), 32'd0);
        check("arst_ready", 32'(wr.wr_ready), 32'd1);
        check_regs("arst_regs", zeros);
        #2;
        reset_n = 1'b1;
        tick();
        check("arst_idle", 32'(clear_busy), 32'd0);

        // async reset with a write sitting in stage 1
        wr.wr_valid = 1'b1; wr.wr_addr = 5'd6; wr.wr_data = 32'h66;
        tick();
        wr.wr_valid = 1'b0;
        check("pipe_onehot", wr_onehot_q, 32'h40);
        #2;
        reset_n = 1'b0;
        #1;
        check("pipe_rst_onehot", wr_onehot_q, 32'd0);
        #1;
        reset_n = 1'b1;
        saw_commit = 1'b0;
        repeat (3) begin
            tick();
            if (commit_valid) saw_commit = 1'b1;
        end
        check("pipe_dropped", 32'(saw_commit), 32'd0);
        check("pipe_r6", dreg(6), 32'd0);

        // randomized traffic against the model
        #1;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 1'b0;
        m_idx  = 0;
        pend.delete();
        tick();
        for (int it = 0; it < 400; it++) begin
            v  = ($urandom_range(0, 9) < 7);
            cr = ($urandom_range(0, 49) == 0);
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            wr.wr_valid = v;
            wr.wr_addr  = a;
            wr.wr_data  = d;
            clear_req   = cr;
            #1;
            check("rnd_ready", 32'(wr.wr_ready), 32'(!m_busy && !cr));
            model_edge(v, a, d, cr);
            tick();
            check("rnd_busy", 32'(clear_busy), 32'(m_busy));
            check("rnd_cv", 32'(commit_valid), 32'(exp_cv));
            if (exp_cv) check("rnd_ca", 32'(commit_addr), 32'(exp_ca));
            check("rnd_onehot", wr_onehot_q, exp_oh);
            check_regs("rnd_regs", m_regs);
        end
        wr.wr_valid = 1'b0;
        clear_req   = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
